qsys_design_button_pio: RTL and testbench

- Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO.
- Samples external push-button/switch lines into the clock domain.
- Latches edges into a write-1-to-clear capture register.
- Raises a level interrupt to the Nios II for unmasked captured edges.
- Sits on the same system interconnect as the LED PIO, with the same 2-bit word address and 32-bit data bus.

---
 rtl/qsys_design_button_pio_if.sv | 25 ++
 rtl/qsys_design_button_pio.sv | 142 ++++++++++++++
 tb/tb_qsys_design_button_pio.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/qsys_design_button_pio_if.sv
// Avalon-MM slave bus for the button PIO: 2-bit word address, 32-bit data.
// The master drives address/strobes/write data; the slave returns readdata.
interface qsys_design_button_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/qsys_design_button_pio.sv
// Button/switch input PIO on the Avalon-MM interconnect.
// Inputs are synchronised, optionally debounced, and edges are latched into
// a write-1-to-clear capture register that drives a masked level interrupt.
// Optional feature macro: PIO_DEBOUNCE_EN (per-bit stable-count debounce).
module qsys_design_button_pio #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,   // 0 rising, 1 falling, 2 any
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    qsys_design_button_pio_if.slave       bus,
    input  logic [WIDTH-1:0]              in_port,
    output logic                          irq
);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] s3_reg;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] capture_reg;
    logic [WIDTH-1:0] capture_next;
    logic [31:0]      readdata_reg;
    logic [31:0]      rd_word;
    logic             rd_en;
    logic             wr_en;
    logic             unused_writedata;

    assign rd_en = bus.chipselect & bus.write_n;
    assign wr_en = bus.chipselect & ~bus.write_n;

    // Only writedata[WIDTH-1:0] carries meaning; fold the rest away.
    assign unused_writedata = ^bus.writedata;

    // Two-flop synchroniser; s3 holds the previous accepted level for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg <= '0;
            s2_reg <= '0;
            s3_reg <= '0;
        end else begin
            s1_reg <= in_port;
            s2_reg <= s1_reg;
            s3_reg <= data_in;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic             level_reg;

            // Accept a new level only after it has been stable for DEBOUNCE_CYCLES.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (s2_reg[gi] == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    level_reg <= s2_reg[gi];
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign data_in[gi] = level_reg;
        end
    endgenerate
`else
    assign data_in = s2_reg;
`endif

    assign rise = data_in & ~s3_reg;
    assign fall = ~data_in & s3_reg;

    // Pick the edge flavour this instance captures.
    always_comb begin
        edge_det = rise | fall;
        case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
    end

    // Write-1-to-clear, then OR in new edges so a coincident edge is never lost.
    always_comb begin
        capture_next = capture_reg;
        if (wr_en && (bus.address == 2'd3)) begin
            capture_next = capture_reg & ~bus.writedata[WIDTH-1:0];
        end
        capture_next = capture_next | edge_det;
    end

    // Capture and mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture_reg <= '0;
            mask_reg    <= '0;
        end else begin
            capture_reg <= capture_next;
            if (wr_en && (bus.address == 2'd2)) begin
                mask_reg <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    // Read mux; upper bits stay zero, direction register reads as zero.
    always_comb begin
        rd_word = '0;
        case (bus.address)
            2'd0:    rd_word[WIDTH-1:0] = data_in;
            2'd2:    rd_word[WIDTH-1:0] = mask_reg;
            2'd3:    rd_word[WIDTH-1:0] = capture_reg;
            default: rd_word = '0;
        endcase
    end

    // One-cycle read latency; readdata holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else if (rd_en) begin
            readdata_reg <= rd_word;
        end
    end

    assign bus.readdata = readdata_reg;
    assign irq          = |(capture_reg & mask_reg);

endmodule

// File: tb/tb_qsys_design_button_pio.sv
// Bench for qsys_design_button_pio: two instances (rising-edge and any-edge)
// share one bus stimulus; read results are scoreboarded per instance.
module tb_qsys_design_button_pio;

`ifdef PIO_DEBOUNCE_EN
    localparam int DEB = 16;
`else
    localparam int DEB = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [3:0]  in0 = '0;
    logic [3:0]  in1 = '0;
    logic        irq0;
    logic        irq1;
    logic        rd_fire = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } rd_exp_t;

    rd_exp_t sb[$];

    always #5 clk = ~clk;

    qsys_design_button_pio_if bus0 ();
    qsys_design_button_pio_if bus1 ();

    assign bus0.address    = address;
    assign bus0.chipselect = chipselect;
    assign bus0.write_n    = write_n;
    assign bus0.writedata  = writedata;
    assign bus1.address    = address;
    assign bus1.chipselect = chipselect;
    assign bus1.write_n    = write_n;
    assign bus1.writedata  = writedata;

    qsys_design_button_pio #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave),
        .in_port (in0),
        .irq     (irq0)
    );

    qsys_design_button_pio #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave),
        .in_port (in1),
        .irq     (irq1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A read was accepted on this edge; its data is due one cycle later.
    always @(posedge clk) begin
        rd_fire <= chipselect & write_n & reset_n;
    end

    // Pop the expected read result and compare both instances.
    always @(negedge clk) begin
        if (rd_fire) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                check({e.tag, "_d0"}, bus0.readdata, e.exp0);
                check({e.tag, "_d1"}, bus1.readdata, e.exp1);
                $display("read %s d0=%h d1=%h", e.tag, bus0.readdata, bus1.readdata);
            end
        end
    end

    // Called at a negedge; returns at the next negedge.
    task automatic bus_read(input logic [1:0] a, input logic [31:0] e0,
                            input logic [31:0] e1, input string tag);
        rd_exp_t e;
        e.tag = tag;
        e.exp0 = e0;
        e.exp1 = e1;
        sb.push_back(e);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("write addr=%0d data=%h", a, d);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rd0", bus0.readdata, 32'h0);
        check("rst_rd1", bus1.readdata, 32'h0);
        check("rst_irq0", {31'b0, irq0}, 32'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state via the bus.
        bus_read(2'd0, 32'h0, 32'h0, "rst_data");
        bus_read(2'd1, 32'h0, 32'h0, "rst_dir");
        bus_read(2'd2, 32'h0, 32'h0, "rst_mask");
        bus_read(2'd3, 32'h0, 32'h0, "rst_cap");
        check("rst_irq1", {31'b0, irq1}, 32'h0);

        // Rising edges on bits 0 and 2; capture lands exactly at k+2.
        in0 = 4'b0101;
        repeat (2 + DEB) @(negedge clk);
        bus_read(2'd3, 32'h0, 32'h0, "cap_early");
        bus_read(2'd3, 32'h5, 32'h0, "cap_5");
        bus_read(2'd0, 32'h5, 32'h0, "data_5");
        check("irq_masked", {31'b0, irq0}, 32'h0);
        bus_write(2'd2, 32'h1);
        check("irq_unmask", {31'b0, irq0}, 32'h1);

        // Partial write-1-to-clear.
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, 32'h1, 32'h0, "clr_part");
        check("irq_part", {31'b0, irq0}, 32'h1);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, 32'h0, 32'h0, "clr_all");
        check("irq_clr", {31'b0, irq0}, 32'h0);

        // Edge on bit 1 coincides with a clear of bit 1: set wins.
        in0 = 4'b0111;
        repeat (2 + DEB) @(negedge clk);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, 32'h2, 32'h0, "set_wins");
        check("irq_bit1_masked", {31'b0, irq0}, 32'h0);

        // Any-edge instance: rising edge on bit 0.
        in1 = 4'b0001;
        repeat (3 + DEB) @(negedge clk);
        bus_read(2'd3, 32'h2, 32'h1, "any_rise");
        check("irq_any", {31'b0, irq1}, 32'h1);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, 32'h2, 32'h0, "any_clr");
        check("irq_any_clr", {31'b0, irq1}, 32'h0);

        // Falling edges: any-edge captures, rising-only does not.
        in1 = 4'b0000;
        in0 = 4'b0000;
        repeat (3 + DEB) @(negedge clk);
        bus_read(2'd3, 32'h2, 32'h1, "any_fall");
        bus_read(2'd0, 32'h0, 32'h0, "data_0");

        // Writes to data and direction are ignored.
        bus_write(2'd0, 32'hF);
        bus_write(2'd1, 32'h5);
        bus_read(2'd0, 32'h0, 32'h0, "ro_data");
        bus_read(2'd1, 32'h0, 32'h0, "ro_dir");
        bus_read(2'd2, 32'h1, 32'h1, "mask_keep");
        bus_read(2'd3, 32'h2, 32'h1, "cap_keep");

`ifdef PIO_DEBOUNCE_EN
        // Short glitch is swallowed; long pulse produces an edge at k+2+DEB.
        bus_write(2'd3, 32'hF);
        bus_read(2'd3, 32'h0, 32'h0, "deb_clr");
        in0 = 4'b0001;
        repeat (10) @(negedge clk);
        in0 = 4'b0000;
        repeat (DEB + 6) @(negedge clk);
        bus_read(2'd3, 32'h0, 32'h0, "glitch_cap");
        bus_read(2'd0, 32'h0, 32'h0, "glitch_data");
        in0 = 4'b0001;
        repeat (2 + DEB) @(negedge clk);
        bus_read(2'd3, 32'h0, 32'h0, "pulse_early");
        bus_read(2'd0, 32'h1, 32'h0, "pulse_data");
        bus_read(2'd3, 32'h1, 32'h0, "pulse_cap");
        in0 = 4'b0000;
        repeat (DEB + 4) @(negedge clk);
        bus_write(2'd3, 32'hE);
        in1 = 4'b0001;
        repeat (3 + DEB) @(negedge clk);
        in1 = 4'b0000;
`endif

        // Mid-operation asynchronous reset clears everything immediately.
        check("pre_rst_irq1", {31'b0, irq1}, 32'h1);
        in0 = 4'b0001;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_irq0", {31'b0, irq0}, 32'h0);
        check("mid_rst_irq1", {31'b0, irq1}, 32'h0);
        check("mid_rst_rd0", bus0.readdata, 32'h0);
        check("mid_rst_rd1", bus1.readdata, 32'h0);
        in0 = 4'b0000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3 + DEB) @(negedge clk);
        bus_read(2'd2, 32'h0, 32'h0, "post_rst_mask");
        bus_read(2'd3, 32'h0, 32'h0, "post_rst_cap");
        bus_read(2'd0, 32'h0, 32'h0, "post_rst_data");

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
